adder_arb: RTL and testbench

Round-robin scheduler that shares one `adder_flex` datapath instance among `NUM_REQ` requesters over valid/ready handshakes. Each accepted request is summed combinationally and captured in a single-entry response register tagged with the requester ID. An optional lock mode chains carry across consecutive operations so that one requester can perform multi-word additions without interruption.

---
 rtl/adder_arb.sv | 152 +++++++++++++++
 tb/tb_adder_arb.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arb.sv
// Round-robin arbiter sharing one adder_flex among NUM_REQ valid/ready requesters.
// Define ADDER_ARB_LOCK_EN to enable carry-chained lock mode for multi-word adds.

module adder_flex #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};

endmodule

module adder_arb #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IDW    = $clog2(NUM_REQ)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_REQ-1:0]       i_req_valid,
    output logic [NUM_REQ-1:0]       o_req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] i_req_a,
    input  logic [NUM_REQ*WIDTH-1:0] i_req_b,
    input  logic [NUM_REQ-1:0]       i_req_cin,
    input  logic [NUM_REQ-1:0]       i_req_lock,
    output logic                     o_rsp_valid,
    output logic [IDW-1:0]           o_rsp_id,
    output logic [WIDTH-1:0]         o_rsp_sum,
    output logic                     o_rsp_cout,
    input  logic                     i_rsp_ready
);

    logic             free;
    logic             found;
    logic             transfer;
    logic [IDW-1:0]   winner;
    logic [IDW-1:0]   ptr_q;
    logic [IDW-1:0]   ptr_next;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic             cin_sel;
    logic             cin_eff;
    logic [WIDTH-1:0] sum_w;
    logic             cout_w;

`ifdef ADDER_ARB_LOCK_EN
    typedef enum logic {Unlocked, Locked} lock_state_e;
    lock_state_e    lock_state_q;
    logic [IDW-1:0] owner_q;
    logic           cc_q;
`endif

    assign free = !o_rsp_valid || i_rsp_ready;

    // Rotating priority search starting at ptr_q; a lock overrides it with the owner.
    always_comb begin : search
        int unsigned idx;
        found  = 1'b0;
        winner = ptr_q;
        idx    = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && i_req_valid[IDW'(idx)]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
`ifdef ADDER_ARB_LOCK_EN
        if (lock_state_q == Locked) begin
            winner = owner_q;
            found  = i_req_valid[owner_q];
        end
`endif
    end

    always_comb begin
        a_sel   = '0;
        b_sel   = '0;
        cin_sel = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (winner == IDW'(i)) begin
                a_sel   = i_req_a[i*WIDTH +: WIDTH];
                b_sel   = i_req_b[i*WIDTH +: WIDTH];
                cin_sel = i_req_cin[i];
            end
        end
    end

`ifdef ADDER_ARB_LOCK_EN
    assign cin_eff = (lock_state_q == Locked) ? cc_q : cin_sel;
`else
    assign cin_eff = cin_sel;
    logic unused_lock;
    assign unused_lock = ^i_req_lock;
`endif

    adder_flex #(
        .WIDTH(WIDTH)
    ) u_adder (
        .a_i   (a_sel),
        .b_i   (b_sel),
        .cin_i (cin_eff),
        .sum_o (sum_w),
        .cout_o(cout_w)
    );

    assign transfer    = found && free && !i_rst;
    assign o_req_ready = transfer ? (NUM_REQ'(1) << winner) : '0;
    assign ptr_next    = (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rsp_valid  <= 1'b0;
            o_rsp_id     <= '0;
            o_rsp_sum    <= '0;
            o_rsp_cout   <= 1'b0;
            ptr_q        <= '0;
`ifdef ADDER_ARB_LOCK_EN
            lock_state_q <= Unlocked;
            owner_q      <= '0;
            cc_q         <= 1'b0;
`endif
        end else if (transfer) begin
            o_rsp_valid <= 1'b1;
            o_rsp_id    <= winner;
            o_rsp_sum   <= sum_w;
            o_rsp_cout  <= cout_w;
            ptr_q       <= ptr_next;
`ifdef ADDER_ARB_LOCK_EN
            // While locked the winner is always the owner, so this covers both acquire and chain.
            if (i_req_lock[winner]) begin
                lock_state_q <= Locked;
                owner_q      <= winner;
                cc_q         <= cout_w;
            end else begin
                lock_state_q <= Unlocked;
            end
`endif
        end else if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adder_arb.sv
// Self-checking bench for adder_arb: directed scenarios plus randomized traffic against
// a transaction-level reference model. Honours ADDER_ARB_LOCK_EN like the design.

module tb_adder_arb;

    localparam int W = 8;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_cin;
    logic [N-1:0]   req_lock;
    logic           rsp_valid;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_sum;
    logic           rsp_cout;
    logic           rsp_ready;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit         pend [N];
    logic [7:0] ma [N];
    logic [7:0] mb [N];
    bit         mc [N];
    bit         ml [N];
    int         m_ptr;
    bit         m_locked;
    int         m_owner;
    bit         m_cc;
    bit         e_valid;
    int         e_id;
    int         e_sum;
    bit         e_cout;

    adder_arb #(
        .WIDTH  (W),
        .NUM_REQ(N)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_req_valid(req_valid),
        .o_req_ready(req_ready),
        .i_req_a    (req_a),
        .i_req_b    (req_b),
        .i_req_cin  (req_cin),
        .i_req_lock (req_lock),
        .o_rsp_valid(rsp_valid),
        .o_rsp_id   (rsp_id),
        .o_rsp_sum  (rsp_sum),
        .o_rsp_cout (rsp_cout),
        .i_rsp_ready(rsp_ready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input bit v, input bit lk, input logic [7:0] a,
                           input logic [7:0] b, input bit c);
        req_valid[k]       = v;
        req_lock[k]        = lk;
        req_a[k*W +: W]    = a;
        req_b[k*W +: W]    = b;
        req_cin[k]         = c;
    endtask

    task automatic clear_reqs;
        req_valid = '0;
        req_lock  = '0;
        req_cin   = '0;
        req_a     = '0;
        req_b     = '0;
    endtask

    task automatic chk_rsp(input string tag, input bit v, input int id, input int sum,
                           input bit cout);
        check_eq({tag, "_valid"}, 32'(rsp_valid), 32'(v));
        check_eq({tag, "_id"}, 32'(rsp_id), 32'(id));
        check_eq({tag, "_sum"}, 32'(rsp_sum), 32'(sum));
        check_eq({tag, "_cout"}, 32'(rsp_cout), 32'(cout));
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic run_random(input int cycles);
        bit r;
        int g;
        int c;
        int s;
        m_ptr = 0; m_locked = 0; m_owner = 0; m_cc = 0;
        e_valid = 0; e_id = 0; e_sum = 0; e_cout = 0;
        for (int k = 0; k < N; k++) pend[k] = 0;
        for (int cyc = 0; cyc < cycles; cyc++) begin
            chk_rsp("rnd_rsp", e_valid, e_id, e_sum, e_cout);
            r = ($urandom_range(0, 63) == 0);
            for (int k = 0; k < N; k++) begin
                if (!pend[k] && $urandom_range(0, 2) != 0) begin
                    pend[k] = 1;
                    ma[k]   = 8'($urandom);
                    mb[k]   = 8'($urandom);
                    mc[k]   = 1'($urandom);
                    ml[k]   = ($urandom_range(0, 3) == 0);
                end
                set_req(k, pend[k], ml[k], ma[k], mb[k], mc[k]);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst       = r;
            g = -1;
            if (!r && (!e_valid || rsp_ready)) begin
                if (m_locked) begin
                    g = pend[m_owner] ? m_owner : -1;
                end else begin
                    for (int i = 0; i < N; i++) begin
                        if (g < 0 && pend[(m_ptr + i) % N]) g = (m_ptr + i) % N;
                    end
                end
            end
            #1;
            check_eq("rnd_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
            if (r) begin
                m_ptr = 0; m_locked = 0; m_cc = 0;
                e_valid = 0; e_id = 0; e_sum = 0; e_cout = 0;
            end else if (g >= 0) begin
                c       = m_locked ? int'(m_cc) : int'(mc[g]);
                s       = int'(ma[g]) + int'(mb[g]) + c;
                e_valid = 1;
                e_id    = g;
                e_sum   = s % 256;
                e_cout  = (s >= 256);
                m_ptr   = (g + 1) % N;
`ifdef ADDER_ARB_LOCK_EN
                m_locked = ml[g];
                m_owner  = g;
                if (ml[g]) m_cc = (s >= 256);
`endif
                pend[g] = 0;
            end else if (rsp_ready) begin
                e_valid = 0;
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        rsp_ready = 1'b0;
        clear_reqs();
        tick();

        // Reset: no ready while in reset, all response fields cleared
        req_valid = '1;
        #1;
        check_eq("reset_ready", 32'(req_ready), 32'd0);
        tick();
        chk_rsp("reset_rsp", 0, 0, 0, 0);
        clear_reqs();
        rst = 1'b0;

        // Single request with wrap-around carry
        set_req(1, 1, 0, 8'hFF, 8'h01, 0);
        #1;
        check_eq("single_ready", 32'(req_ready), 32'b0010);
        tick();
        chk_rsp("single_rsp", 1, 1, 0, 1);
        clear_reqs();
        rsp_ready = 1'b1;
        tick();
        check_eq("single_drain", 32'(rsp_valid), 32'd0);

        // Fairness: all valid, grants rotate 0,1,2,3,0,1
        do_reset();
        for (int k = 0; k < N; k++) set_req(k, 1, 0, 8'(16 * k), 8'(k), 0);
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check_eq("fair_ready", 32'(req_ready), 32'd1 << (i % N));
            tick();
            chk_rsp("fair_rsp", 1, i % N, 17 * (i % N), 0);
        end

        // Backpressure: slot full holds id 1 for three cycles, then drain and accept together
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("bp_ready", 32'(req_ready), 32'd0);
            tick();
            chk_rsp("bp_hold", 1, 1, 17, 0);
        end
        rsp_ready = 1'b1;
        #1;
        check_eq("bp_accept_ready", 32'(req_ready), 32'b0100);
        tick();
        chk_rsp("bp_accept_rsp", 1, 2, 34, 0);
        clear_reqs();
        tick();

        // Lock chain: req2 two-word add, req0 waiting
        do_reset();
        set_req(2, 1, 1, 8'hFF, 8'h00, 1);
        #1;
        check_eq("lock_first_ready", 32'(req_ready), 32'b0100);
        tick();
        chk_rsp("lock_first_rsp", 1, 2, 8'h00, 1);
        set_req(0, 1, 0, 8'h05, 8'h05, 0);
`ifdef ADDER_ARB_LOCK_EN
        req_valid[2] = 1'b0;
        #1;
        check_eq("lock_idle_ready", 32'(req_ready), 32'd0);
        tick();
        set_req(2, 1, 0, 8'h00, 8'h00, 0);
        #1;
        check_eq("lock_second_ready", 32'(req_ready), 32'b0100);
        tick();
        chk_rsp("lock_second_rsp", 1, 2, 8'h01, 0);
        req_valid[2] = 1'b0;
        #1;
        check_eq("lock_req0_ready", 32'(req_ready), 32'b0001);
        tick();
        chk_rsp("lock_req0_rsp", 1, 0, 8'h0A, 0);
`else
        set_req(2, 1, 0, 8'h00, 8'h00, 0);
        #1;
        check_eq("nolock_req0_ready", 32'(req_ready), 32'b0001);
        tick();
        chk_rsp("nolock_req0_rsp", 1, 0, 8'h0A, 0);
        req_valid[0] = 1'b0;
        #1;
        check_eq("nolock_second_ready", 32'(req_ready), 32'b0100);
        tick();
        chk_rsp("nolock_second_rsp", 1, 2, 8'h00, 0);
`endif
        clear_reqs();
        tick();

        // Reset while req3 holds the lock with a response pending
        do_reset();
        rsp_ready = 1'b0;
        set_req(3, 1, 1, 8'hFF, 8'h01, 0);
        #1;
        check_eq("rmid_lock_ready", 32'(req_ready), 32'b1000);
        tick();
        chk_rsp("rmid_lock_rsp", 1, 3, 8'h00, 1);
        rst       = 1'b1;
        rsp_ready = 1'b1;
        set_req(3, 1, 0, 8'h01, 8'h01, 0);
        set_req(0, 1, 0, 8'h02, 8'h03, 0);
        #1;
        check_eq("rmid_rst_ready", 32'(req_ready), 32'd0);
        tick();
        check_eq("rmid_rsp_dropped", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        #1;
        check_eq("rmid_req0_ready", 32'(req_ready), 32'b0001);
        tick();
        chk_rsp("rmid_req0_rsp", 1, 0, 8'h05, 0);
        req_valid[0] = 1'b0;
        #1;
        check_eq("rmid_req3_ready", 32'(req_ready), 32'b1000);
        tick();
        chk_rsp("rmid_req3_rsp", 1, 3, 8'h02, 0);
        clear_reqs();
        tick();

        // Randomized traffic against the reference model
        do_reset();
        run_random(3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
